// File: rtl/segre_mext_unit.sv
// segre_mext_unit: RV32M execute unit with a fixed-latency multiply pipeline and a radix-2 restoring divider.
// Optional flush input kill_i is enabled by defining SEGRE_MEXT_KILL_EN.
module segre_mext_unit #(
  parameter int MUL_STAGES = 5,
  parameter int XLEN       = 32,
  parameter int REG_SIZE   = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef SEGRE_MEXT_KILL_EN
  input  logic                kill_i,
`endif
  input  logic                valid_m1_i,
  input  logic [2:0]          m1_opcode_i,
  input  logic [REG_SIZE-1:0] m1_rf_waddr_i,
  input  logic [XLEN-1:0]     m1_src_a_i,
  input  logic [XLEN-1:0]     m1_src_b_i,
  output logic                ready_o,
  output logic                wb_valid_o,
  output logic [REG_SIZE-1:0] wb_waddr_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [31:0]         pending_o
);

  localparam int   CNT_W         = $clog2(XLEN + 1);
  localparam logic MUL_IMMEDIATE = (MUL_STAGES == 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

  logic kill;
`ifdef SEGRE_MEXT_KILL_EN
  assign kill = kill_i;
`else
  assign kill = 1'b0;
`endif

  div_state_e          div_state;
  logic [CNT_W-1:0]    div_cnt;
  logic [XLEN-1:0]     div_rem;
  logic [XLEN-1:0]     div_quo;
  logic [XLEN-1:0]     div_dvsr;
  logic                div_q_neg;
  logic                div_r_neg;
  logic                div_rem_op;
  logic [REG_SIZE-1:0] div_waddr;

  logic                is_div;
  logic                accept;
  logic                mul_accept;
  logic                div_accept;
  logic                mul_pipe_empty;
  logic                mul_last_valid;
  logic [REG_SIZE-1:0] mul_last_waddr;
  logic [XLEN-1:0]     mul_last_data;

  // Opcode follows funct3: bit2 selects divide, bits[1:0] pick the variant.
  assign is_div     = m1_opcode_i[2];
  assign ready_o    = !rst_i && !kill && (div_state == DIV_IDLE) && (!is_div || mul_pipe_empty);
  assign accept     = valid_m1_i && ready_o;
  assign mul_accept = accept && !is_div;
  assign div_accept = accept && is_div;

  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] mul_product;
  logic [XLEN-1:0]   mul_res;

  // Only the low 2*XLEN bits of the extended product matter, so a plain wide multiply suffices.
  always_comb begin
    mul_a_ext   = {{XLEN{(m1_opcode_i[1:0] != 2'b11) && m1_src_a_i[XLEN-1]}}, m1_src_a_i};
    mul_b_ext   = {{XLEN{!m1_opcode_i[1] && m1_src_b_i[XLEN-1]}}, m1_src_b_i};
    mul_product = mul_a_ext * mul_b_ext;
    mul_res     = (m1_opcode_i[1:0] == 2'b00) ? mul_product[XLEN-1:0] : mul_product[2*XLEN-1:XLEN];
  end

  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_pipe_empty = 1'b1;
      assign mul_last_valid = mul_accept;
      assign mul_last_waddr = m1_rf_waddr_i;
      assign mul_last_data  = mul_res;
    end else begin : g_mul_pipe
      logic [MUL_STAGES-1:1] stage_valid;
      logic [REG_SIZE-1:0]   stage_waddr [1:MUL_STAGES-1];
      logic [XLEN-1:0]       stage_data  [1:MUL_STAGES-1];

      always_ff @(posedge clk_i) begin
        if (rst_i || kill) begin
          stage_valid <= '0;
        end else begin
          stage_valid[1] <= mul_accept;
          for (int i = 2; i < MUL_STAGES; i++) begin
            stage_valid[i] <= stage_valid[i-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        stage_waddr[1] <= m1_rf_waddr_i;
        stage_data[1]  <= mul_res;
        for (int i = 2; i < MUL_STAGES; i++) begin
          stage_waddr[i] <= stage_waddr[i-1];
          stage_data[i]  <= stage_data[i-1];
        end
      end

      assign mul_pipe_empty = (stage_valid == '0);
      assign mul_last_valid = stage_valid[MUL_STAGES-1];
      assign mul_last_waddr = stage_waddr[MUL_STAGES-1];
      assign mul_last_data  = stage_data[MUL_STAGES-1];
    end
  endgenerate

  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            div_ovf;
  logic            div_special;
  logic [XLEN-1:0] special_res;

  // Division by zero and signed overflow bypass the iteration with fixed RISC-V results.
  always_comb begin
    div_signed  = !m1_opcode_i[0];
    a_neg       = div_signed && m1_src_a_i[XLEN-1];
    b_neg       = div_signed && m1_src_b_i[XLEN-1];
    a_mag       = a_neg ? -m1_src_a_i : m1_src_a_i;
    b_mag       = b_neg ? -m1_src_b_i : m1_src_b_i;
    b_zero      = (m1_src_b_i == '0);
    div_ovf     = div_signed && (m1_src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (m1_src_b_i == '1);
    div_special = b_zero || div_ovf;
    if (b_zero) begin
      special_res = m1_opcode_i[1] ? m1_src_a_i : '1;
    end else begin
      special_res = m1_opcode_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] calc_res;

  always_comb begin
    rem_shift = {div_rem, div_quo[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, div_dvsr};
    rem_next  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
    quo_next  = {div_quo[XLEN-2:0], !rem_diff[XLEN]};
    if (div_rem_op) begin
      calc_res = div_r_neg ? -rem_next : rem_next;
    end else begin
      calc_res = div_q_neg ? -quo_next : quo_next;
    end
  end

  logic                div_finish;
  logic [XLEN-1:0]     div_finish_data;
  logic [REG_SIZE-1:0] div_finish_waddr;

  assign div_finish       = ((div_state == DIV_CALC) && (div_cnt == CNT_W'(1))) || (div_accept && div_special);
  assign div_finish_data  = (div_state == DIV_IDLE) ? special_res : calc_res;
  assign div_finish_waddr = (div_state == DIV_IDLE) ? m1_rf_waddr_i : div_waddr;

  // The result enters the wb registers on the edge into DONE, so DONE is the writeback cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || kill) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (div_accept) begin
            div_rem    <= '0;
            div_quo    <= a_mag;
            div_dvsr   <= b_mag;
            div_cnt    <= CNT_W'(XLEN);
            div_q_neg  <= a_neg ^ b_neg;
            div_r_neg  <= a_neg;
            div_rem_op <= m1_opcode_i[1];
            div_waddr  <= m1_rf_waddr_i;
            div_state  <= div_special ? DIV_DONE : DIV_CALC;
          end
        end
        DIV_CALC: begin
          div_rem <= rem_next;
          div_quo <= quo_next;
          div_cnt <= div_cnt - 1'b1;
          if (div_cnt == CNT_W'(1)) begin
            div_state <= DIV_DONE;
          end
        end
        DIV_DONE: div_state <= DIV_IDLE;
        default:  div_state <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_waddr_o <= '0;
      wb_data_o  <= '0;
    end else if (kill) begin
      wb_valid_o <= 1'b0;
    end else if (mul_last_valid) begin
      wb_valid_o <= 1'b1;
      wb_waddr_o <= mul_last_waddr;
      wb_data_o  <= mul_last_data;
    end else if (div_finish) begin
      wb_valid_o <= 1'b1;
      wb_waddr_o <= div_finish_waddr;
      wb_data_o  <= div_finish_data;
    end else begin
      wb_valid_o <= 1'b0;
    end
  end

  logic [31:0] pending_q;
  logic [31:0] accept_mask;
  logic [31:0] set_mask;
  logic [31:0] clear_mask;
  logic        load_valid;
  logic [REG_SIZE-1:0] load_waddr;

  // Ops that write back on their own accept edge never enter the registered mask.
  always_comb begin
    accept_mask = (accept && (m1_rf_waddr_i != '0)) ? (32'd1 << m1_rf_waddr_i) : '0;
    set_mask    = ((mul_accept && MUL_IMMEDIATE) || (div_accept && div_special)) ? '0 : accept_mask;
    load_valid  = mul_last_valid || div_finish;
    load_waddr  = mul_last_valid ? mul_last_waddr : div_finish_waddr;
    clear_mask  = load_valid ? (32'd1 << load_waddr) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || kill) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clear_mask) | set_mask;
    end
  end

  assign pending_o = pending_q | accept_mask;

endmodule

// File: tb/tb_segre_mext_unit.sv
// tb_segre_mext_unit: directed self-checking bench for segre_mext_unit.
// Kill scenarios are exercised only when SEGRE_MEXT_KILL_EN is defined.
module tb_segre_mext_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  opcode;
  logic [4:0]  waddr;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ready;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic [31:0] pending;
`ifdef SEGRE_MEXT_KILL_EN
  logic        kill;
`endif

  int test_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  segre_mext_unit #(.MUL_STAGES(5), .XLEN(32), .REG_SIZE(5)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef SEGRE_MEXT_KILL_EN
    .kill_i        (kill),
`endif
    .valid_m1_i    (valid),
    .m1_opcode_i   (opcode),
    .m1_rf_waddr_i (waddr),
    .m1_src_a_i    (src_a),
    .m1_src_b_i    (src_b),
    .ready_o       (ready),
    .wb_valid_o    (wb_valid),
    .wb_waddr_o    (wb_waddr),
    .wb_data_o     (wb_data),
    .pending_o     (pending)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [4:0] wa,
                                input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    opcode = op;
    waddr  = wa;
    src_a  = a;
    src_b  = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issues one divide-class op and waits (bounded) for its writeback, checking ready stays low meanwhile.
  task automatic run_div(input string tag, input logic [2:0] op, input logic [4:0] wa,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input int exp_lat);
    int   cycles;
    logic seen;
    next_cycle();
    apply_stimulus(op, wa, a, b);
    #1;
    check_output({tag, " ready c0"}, 32'(ready), 32'd1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      next_cycle();
      valid = 1'b0;
      cycles++;
      #1;
      check_output({tag, " ready busy"}, 32'(ready), 32'd0);
      seen = wb_valid;
    end
    check_output({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check_output({tag, " data"}, wb_data, exp_data);
    check_output({tag, " waddr"}, 32'(wb_waddr), 32'(wa));
  endtask

  initial begin
    int   cycles;
    logic seen;
    rst    = 1'b1;
    valid  = 1'b0;
    opcode = OP_MUL;
    waddr  = 5'd0;
    src_a  = 32'd0;
    src_b  = 32'd0;
`ifdef SEGRE_MEXT_KILL_EN
    kill   = 1'b0;
`endif

    repeat (3) next_cycle();
    #1;
    check_output("reset ready", 32'(ready), 32'd0);
    check_output("reset wb_valid", 32'(wb_valid), 32'd0);
    check_output("reset wb_waddr", 32'(wb_waddr), 32'd0);
    check_output("reset wb_data", wb_data, 32'd0);
    check_output("reset pending", pending, 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check_output("ready after reset", 32'(ready), 32'd1);

    // Single MUL: 7 * -3 = -21 written to x5 five cycles later.
    next_cycle();
    apply_stimulus(OP_MUL, 5'd5, 32'd7, 32'hFFFF_FFFD);
    #1;
    check_output("mul ready c0", 32'(ready), 32'd1);
    check_output("mul pending c0", pending, 32'h0000_0020);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      valid = 1'b0;
      #1;
      check_output("mul pending in flight", pending, 32'h0000_0020);
      check_output("mul wb early", 32'(wb_valid), 32'd0);
    end
    next_cycle();
    #1;
    check_output("mul wb_valid c5", 32'(wb_valid), 32'd1);
    check_output("mul wb_waddr c5", 32'(wb_waddr), 32'd5);
    check_output("mul wb_data c5", wb_data, 32'hFFFF_FFEB);
    check_output("mul pending c5", pending, 32'd0);
    next_cycle();
    #1;
    check_output("mul wb_valid c6", 32'(wb_valid), 32'd0);
    check_output("mul wb_data hold", wb_data, 32'hFFFF_FFEB);

    // Back-to-back high-half multiplies of all-ones operands.
    next_cycle();
    apply_stimulus(OP_MULHU, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    next_cycle();
    apply_stimulus(OP_MULH, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    next_cycle();
    apply_stimulus(OP_MULHSU, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    next_cycle();
    valid = 1'b0;
    #1;
    check_output("b2b pending c3", pending, 32'h0000_000E);
    next_cycle();
    #1;
    check_output("b2b wb c4", 32'(wb_valid), 32'd0);
    next_cycle();
    #1;
    check_output("mulhu wb_valid", 32'(wb_valid), 32'd1);
    check_output("mulhu waddr", 32'(wb_waddr), 32'd1);
    check_output("mulhu data", wb_data, 32'hFFFF_FFFE);
    check_output("b2b pending c5", pending, 32'h0000_000C);
    next_cycle();
    #1;
    check_output("mulh wb_valid", 32'(wb_valid), 32'd1);
    check_output("mulh waddr", 32'(wb_waddr), 32'd2);
    check_output("mulh data", wb_data, 32'h0000_0000);
    next_cycle();
    #1;
    check_output("mulhsu wb_valid", 32'(wb_valid), 32'd1);
    check_output("mulhsu waddr", 32'(wb_waddr), 32'd3);
    check_output("mulhsu data", wb_data, 32'hFFFF_FFFF);
    check_output("b2b pending c7", pending, 32'd0);
    next_cycle();
    #1;
    check_output("b2b wb c8", 32'(wb_valid), 32'd0);

    // Write to x0: still computed and written back, never marked pending.
    next_cycle();
    apply_stimulus(OP_MUL, 5'd0, 32'd2, 32'd3);
    #1;
    check_output("x0 pending c0", pending, 32'd0);
    next_cycle();
    valid = 1'b0;
    #1;
    check_output("x0 pending c1", pending, 32'd0);
    repeat (3) next_cycle();
    next_cycle();
    #1;
    check_output("x0 wb_valid", 32'(wb_valid), 32'd1);
    check_output("x0 waddr", 32'(wb_waddr), 32'd0);
    check_output("x0 data", wb_data, 32'd6);

    // Divider: normal iterations and special cases.
    run_div("div -7/2",   OP_DIV,  5'd7,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_div("rem -7/2",   OP_REM,  5'd8,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_div("divu 100/7", OP_DIVU, 5'd9,  32'd100,       32'd7,         32'd14,        33);
    run_div("remu 100/7", OP_REMU, 5'd10, 32'd100,       32'd7,         32'd2,         33);
    run_div("div 7/-2",   OP_DIV,  5'd11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_div("rem 7/-2",   OP_REM,  5'd12, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_div("divu 5/0",   OP_DIVU, 5'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_div("remu 5/0",   OP_REMU, 5'd14, 32'd5,         32'd0,         32'd5,         1);
    run_div("rem -7/0",   OP_REM,  5'd15, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
    run_div("div ovf",    OP_DIV,  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_div("rem ovf",    OP_REM,  5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // A divide waits for the multiply pipe to drain before it is accepted.
    next_cycle();
    apply_stimulus(OP_MUL, 5'd9, 32'd3, 32'd4);
    next_cycle();
    apply_stimulus(OP_DIVU, 5'd10, 32'd100, 32'd7);
    #1;
    check_output("mix ready c1", 32'(ready), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      #1;
      check_output("mix ready drain", 32'(ready), 32'd0);
    end
    next_cycle();
    #1;
    check_output("mix ready c5", 32'(ready), 32'd1);
    check_output("mix mul wb_valid", 32'(wb_valid), 32'd1);
    check_output("mix mul waddr", 32'(wb_waddr), 32'd9);
    check_output("mix mul data", wb_data, 32'd12);
    check_output("mix pending c5", pending, 32'h0000_0400);
    next_cycle();
    valid = 1'b0;
    #1;
    check_output("mix wb c6", 32'(wb_valid), 32'd0);
    check_output("mix pending c6", pending, 32'h0000_0400);
    cycles = 6;
    while (!wb_valid && cycles < 60) begin
      next_cycle();
      cycles++;
      #1;
    end
    check_output("mix div cycle", 32'(cycles), 32'd38);
    check_output("mix div data", wb_data, 32'd14);
    check_output("mix div waddr", 32'(wb_waddr), 32'd10);

    // Reset during a divide drops it without writeback.
    next_cycle();
    apply_stimulus(OP_DIV, 5'd12, 32'd1000, 32'd3);
    repeat (9) begin
      next_cycle();
      valid = 1'b0;
    end
    next_cycle();
    rst = 1'b1;
    #1;
    check_output("rst ready c10", 32'(ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check_output("rst ready c11", 32'(ready), 32'd1);
    check_output("rst wb_valid c11", 32'(wb_valid), 32'd0);
    check_output("rst pending c11", pending, 32'd0);
    check_output("rst wb_data c11", wb_data, 32'd0);
    check_output("rst wb_waddr c11", 32'(wb_waddr), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      next_cycle();
      #1;
      if (wb_valid) seen = 1'b1;
    end
    check_output("rst no late wb", 32'(seen), 32'd0);

`ifdef SEGRE_MEXT_KILL_EN
    // Kill mid-multiply flushes the op and its pending bit.
    next_cycle();
    apply_stimulus(OP_MUL, 5'd6, 32'd5, 32'd5);
    next_cycle();
    valid = 1'b0;
    next_cycle();
    next_cycle();
    kill = 1'b1;
    #1;
    check_output("kill ready c3", 32'(ready), 32'd0);
    next_cycle();
    kill = 1'b0;
    #1;
    check_output("kill pending c4", pending, 32'd0);
    check_output("kill wb c4", 32'(wb_valid), 32'd0);
    next_cycle();
    #1;
    check_output("kill wb c5", 32'(wb_valid), 32'd0);
    check_output("kill pending c5", pending, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
